// File: rtl/dmem_hs.sv
// Handshaked multi-cycle byte-addressed data memory (big-endian) with a
// parametrised access latency, load sign-extension and fault reporting.
module dmem_hs #(
  parameter int          SIZE    = 32768,
  parameter int          LATENCY = 2,
  parameter logic [31:0] OFFSET  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [0:31] addr,
  input  logic [0:31] wData,
  input  logic [0:1]  dsize,
  input  logic        signExt,
  output logic        ack,
  output logic        fault,
  output logic [0:31] rData
);

  localparam int AW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic            r_sext;
  logic            r_err;
  logic [1:0]      r_dsize;
  logic [31:0]     r_wdata;
  logic [AW-1:0]   r_idx;
  logic            r_ack;
  logic            r_fault;
  logic [31:0]     r_rdata;

  logic [7:0]      mem [0:SIZE-1];

  logic [31:0]     w_addr;
  logic [31:0]     w_phys;
  logic [1:0]      w_dsize;
  logic            w_err;
  logic [AW-1:0]   w_i0, w_i1, w_i2, w_i3;
  logic [7:0]      w_b0, w_b1, w_b2, w_b3;
  logic [31:0]     w_load;

  assign w_addr  = addr;
  assign w_dsize = dsize;
  assign w_phys  = w_addr - OFFSET;

  // The range compare is a plain 32-bit unsigned one, so an address below
  // OFFSET wraps to a huge index and faults.
  assign w_err = (w_dsize == 2'd2)
              || (w_dsize == 2'd1 && w_phys[0])
              || (w_dsize == 2'd3 && w_phys[1:0] != 2'd0)
              || ((w_phys + 32'(w_dsize)) >= 32'(SIZE));

  assign w_i0 = r_idx;
  assign w_i1 = r_idx + AW'(1);
  assign w_i2 = r_idx + AW'(2);
  assign w_i3 = r_idx + AW'(3);
  assign w_b0 = mem[w_i0];
  assign w_b1 = mem[w_i1];
  assign w_b2 = mem[w_i2];
  assign w_b3 = mem[w_i3];

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_load = '0;
    unique case (r_dsize)
      2'd3:    w_load = {w_b0, w_b1, w_b2, w_b3};
      2'd1:    w_load = {{16{r_sext & w_b0[7]}}, w_b0, w_b1};
      default: w_load = {{24{r_sext & w_b0[7]}}, w_b0};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_err   <= 1'b0;
      r_dsize <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_ack   <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_fault <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_sext  <= signExt;
            r_err   <= w_err;
            r_dsize <= w_dsize;
            r_wdata <= wData;
            r_idx   <= w_phys[AW-1:0];
            r_cnt   <= 4'(LATENCY);
            r_state <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        RESP: begin
          r_ack   <= 1'b1;
          r_fault <= r_err;
          r_rdata <= (r_err || r_we) ? 32'h0 : w_load;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are owned by the
  // environment and clearing it would need a per-word write port.
  always_ff @(posedge clk) begin
    if (r_state == RESP && r_we && !r_err) begin
      unique case (r_dsize)
        2'd3: begin
          mem[w_i0] <= r_wdata[31:24];
          mem[w_i1] <= r_wdata[23:16];
          mem[w_i2] <= r_wdata[15:8];
          mem[w_i3] <= r_wdata[7:0];
        end
        2'd1: begin
          mem[w_i0] <= r_wdata[15:8];
          mem[w_i1] <= r_wdata[7:0];
        end
        default: mem[w_i0] <= r_wdata[7:0];
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign ack   = r_ack;
  assign fault = r_fault;
  assign rData = r_rdata;

endmodule
